// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: control sequencer for one PE.
// Walks fixed control-step sequences for the dot-product (DOT), element-wise (EWISE) and
// distance (DIST) operations. Each step is held for a programmable number of cycles. For DOT
// and DIST, the PE total is captured on the final adder-tree cycle.
// Optional feature: define PE_SEQ_ABORT_EN to add an 'abort' input that cancels a running
// sequence. Cancelling returns the block to IDLE without a result.
module pe_seq_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STEP_CYCLES = 10,
    parameter int unsigned ADD_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
`ifdef PE_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              mode_err,
    output logic [1:0]        sel_cu,
    output logic [1:0]        sel_cu_go_back,
    output logic [1:0]        sel_adder,
    output logic              is_save_cu_out,
    input  logic [DATA_W-1:0] pe_out_total,
    output logic [DATA_W-1:0] result_total,
    output logic              result_valid
);

    localparam int unsigned MAX_CYC = (STEP_CYCLES > ADD_CYCLES) ? STEP_CYCLES : ADD_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] MODE_DOT   = 2'b00;
    localparam logic [1:0] MODE_EWISE = 2'b01;
    localparam logic [1:0] MODE_DIST  = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [1:0] CU_NONE = 2'b00;
    localparam logic [1:0] CU_ADD  = 2'b10;
    localparam logic [1:0] CU_MUL  = 2'b11;

    localparam logic [1:0] GB_NONE = 2'b00;
    localparam logic [1:0] GB_FWD  = 2'b10;
    localparam logic [1:0] GB_PAR  = 2'b01;
    localparam logic [1:0] GB_IN   = 2'b11;

    localparam logic [1:0] AD_NONE = 2'b00;
    localparam logic [1:0] AD_TREE = 2'b10;
    localparam logic [1:0] AD_BYP  = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CU1   = 4'd1,
        S_SAVE  = 4'd2,
        S_GOPAR = 4'd3,
        S_GOIN  = 4'd4,
        S_CU2   = 4'd5,
        S_FWD   = 4'd6,
        S_ADD   = 4'd7,
        S_DONE  = 4'd8
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               mode_err_q, mode_err_d;
    logic [1:0]         sel_cu_q, sel_cu_d;
    logic [1:0]         go_back_q, go_back_d;
    logic [1:0]         sel_adder_q, sel_adder_d;
    logic               save_q, save_d;
    logic [DATA_W-1:0]  result_total_q, result_total_d;
    logic               result_valid_q, result_valid_d;

    logic               step_last_c;
    logic               abort_c;
    logic               is_dist_c;

`ifdef PE_SEQ_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Last cycle of the current timed step (ADD has its own hold length).
    always_comb begin
        step_last_c = 1'b0;
        if (state_q == S_ADD) begin
            step_last_c = (cnt_q == CNT_W'(ADD_CYCLES - 1));
        end else begin
            step_last_c = (cnt_q == CNT_W'(STEP_CYCLES - 1));
        end
    end

    // Next-state, step counter, capture and registered control outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        mode_err_d     = 1'b0;
        result_total_d = result_total_q;
        result_valid_d = 1'b0;
        busy_d         = 1'b0;
        sel_cu_d       = CU_NONE;
        go_back_d      = GB_NONE;
        sel_adder_d    = AD_NONE;
        save_d         = 1'b0;
        is_dist_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (mode == MODE_RSVD) begin
                        mode_err_d = 1'b1;
                    end else begin
                        state_d = S_CU1;
                        mode_d  = mode;
                    end
                end
            end
            S_CU1: begin
                if (step_last_c) begin
                    state_d = (mode_q == MODE_DIST) ? S_SAVE : S_FWD;
                end
            end
            S_SAVE: begin
                if (step_last_c) state_d = S_GOPAR;
            end
            S_GOPAR: begin
                if (step_last_c) state_d = S_GOIN;
            end
            S_GOIN: begin
                if (step_last_c) state_d = S_CU2;
            end
            S_CU2: begin
                if (step_last_c) state_d = S_FWD;
            end
            S_FWD: begin
                if (step_last_c) state_d = S_ADD;
            end
            S_ADD: begin
                if (step_last_c) begin
                    state_d = S_DONE;
                    if (mode_q != MODE_EWISE) begin
                        result_total_d = pe_out_total;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter runs inside timed steps and reloads on every step change.
        if (state_q == S_IDLE || state_q == S_DONE) begin
            cnt_d = '0;
        end else if (step_last_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Abort cancels any timed step; the pending capture is dropped with it.
        if (abort_c && state_q != S_IDLE && state_q != S_DONE) begin
            state_d        = S_IDLE;
            cnt_d          = '0;
            result_total_d = result_total_q;
        end

        // Controls are cumulative along a sequence, so they follow from (next state, mode).
        is_dist_c = (mode_d == MODE_DIST);
        case (state_d)
            S_CU1: begin
                sel_cu_d = is_dist_c ? CU_ADD : CU_MUL;
            end
            S_SAVE: begin
                sel_cu_d = CU_ADD;
                save_d   = 1'b1;
            end
            S_GOPAR: begin
                sel_cu_d  = CU_ADD;
                save_d    = 1'b1;
                go_back_d = GB_PAR;
            end
            S_GOIN: begin
                sel_cu_d  = CU_ADD;
                save_d    = 1'b1;
                go_back_d = GB_IN;
            end
            S_CU2: begin
                sel_cu_d  = CU_MUL;
                save_d    = 1'b1;
                go_back_d = GB_IN;
            end
            S_FWD: begin
                sel_cu_d  = CU_MUL;
                save_d    = is_dist_c;
                go_back_d = GB_FWD;
            end
            S_ADD: begin
                sel_cu_d    = CU_MUL;
                save_d      = is_dist_c;
                go_back_d   = GB_FWD;
                sel_adder_d = (mode_d == MODE_EWISE) ? AD_BYP : AD_TREE;
            end
            default: begin
                sel_cu_d = CU_NONE;
            end
        endcase

        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            mode_q         <= MODE_DOT;
            busy_q         <= 1'b0;
            mode_err_q     <= 1'b0;
            sel_cu_q       <= CU_NONE;
            go_back_q      <= GB_NONE;
            sel_adder_q    <= AD_NONE;
            save_q         <= 1'b0;
            result_total_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mode_q         <= mode_d;
            busy_q         <= busy_d;
            mode_err_q     <= mode_err_d;
            sel_cu_q       <= sel_cu_d;
            go_back_q      <= go_back_d;
            sel_adder_q    <= sel_adder_d;
            save_q         <= save_d;
            result_total_q <= result_total_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy           = busy_q;
    assign mode_err       = mode_err_q;
    assign sel_cu         = sel_cu_q;
    assign sel_cu_go_back = go_back_q;
    assign sel_adder      = sel_adder_q;
    assign is_save_cu_out = save_q;
    assign result_total   = result_total_q;
    assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Testbench for pe_seq_ctrl: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a queue-based timeline model of the sequences.
// Build with PE_SEQ_ABORT_EN defined to exercise the abort input as well.
module tb_pe_seq_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned S      = 10;
    localparam int unsigned A      = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
`ifdef PE_SEQ_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic              busy, mode_err, is_save_cu_out, result_valid;
    logic [1:0]        sel_cu, sel_cu_go_back, sel_adder;
    logic [DATA_W-1:0] pe_out_total = '0;
    logic [DATA_W-1:0] result_total;

    int n_cmp = 0;
    int n_bad = 0;

    pe_seq_ctrl #(.DATA_W(DATA_W), .STEP_CYCLES(S), .ADD_CYCLES(A)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
`ifdef PE_SEQ_ABORT_EN
        .abort          (abort),
`endif
        .busy           (busy),
        .mode_err       (mode_err),
        .sel_cu         (sel_cu),
        .sel_cu_go_back (sel_cu_go_back),
        .sel_adder      (sel_adder),
        .is_save_cu_out (is_save_cu_out),
        .pe_out_total   (pe_out_total),
        .result_total   (result_total),
        .result_valid   (result_valid)
    );

    always #5 clk = ~clk;

    // Model: each accepted sequence is expanded into one entry per cycle.
    // Entry bits: [10] capture, [9] busy, [8] mode_err, [7:6] sel_cu, [5:4] go_back,
    // [3:2] sel_adder, [1] save, [0] result_valid.
    logic [10:0]       mq[$];
    logic [9:0]        m_ctl;
    logic [DATA_W-1:0] m_res;

    function automatic logic [10:0] mk(input logic [1:0] cu, input logic [1:0] gb,
                                       input logic [1:0] ad, input logic sv);
        return {1'b0, 1'b1, 1'b0, cu, gb, ad, sv, 1'b0};
    endfunction

    task automatic push_n(input logic [10:0] e, input int n);
        for (int i = 0; i < n; i++) mq.push_back(e);
    endtask

    task automatic build(input logic [1:0] md);
        if (md == 2'b10) begin
            push_n(mk(2'b10, 2'b00, 2'b00, 1'b0), S);
            push_n(mk(2'b10, 2'b00, 2'b00, 1'b1), S);
            push_n(mk(2'b10, 2'b01, 2'b00, 1'b1), S);
            push_n(mk(2'b10, 2'b11, 2'b00, 1'b1), S);
            push_n(mk(2'b11, 2'b11, 2'b00, 1'b1), S);
            push_n(mk(2'b11, 2'b10, 2'b00, 1'b1), S);
            push_n(mk(2'b11, 2'b10, 2'b10, 1'b1), A);
            mq.push_back(11'b11_0000_0000_1);
        end else begin
            push_n(mk(2'b11, 2'b00, 2'b00, 1'b0), S);
            push_n(mk(2'b11, 2'b10, 2'b00, 1'b0), S);
            if (md == 2'b01) begin
                push_n(mk(2'b11, 2'b10, 2'b01, 1'b0), A);
                mq.push_back(11'b01_0000_0000_1);
            end else begin
                push_n(mk(2'b11, 2'b10, 2'b10, 1'b0), A);
                mq.push_back(11'b11_0000_0000_1);
            end
        end
    endtask

    // Model update on each rising edge from the inputs held during the ending cycle.
    always @(posedge clk) begin
        logic [10:0] e;
        logic        err;
        logic        cut;
        if (!rst) begin
            mq.delete();
            m_ctl = '0;
            m_res = '0;
        end else begin
            err = 1'b0;
            cut = 1'b0;
`ifdef PE_SEQ_ABORT_EN
            if (abort && m_ctl[9] && !m_ctl[0]) begin
                mq.delete();
                cut = 1'b1;
            end
`endif
            if (!cut && !m_ctl[9] && start) begin
                if (mode == 2'b11) err = 1'b1;
                else build(mode);
            end
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_ctl = e[9:0];
                if (e[10]) m_res = pe_out_total;
            end else begin
                m_ctl = '0;
            end
            m_ctl[8] = err;
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: wait for the falling edge, then compare DUT against the model.
    task automatic tick();
        @(negedge clk);
        pin("ctl_vs_model",
            32'({busy, mode_err, sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out, result_valid}),
            32'(m_ctl));
        pin("result_vs_model", result_total, m_res);
    endtask

    // Run one sequence from IDLE with literal timing/result checks.
    task automatic run_seq(input logic [1:0] md, input int len, input logic [31:0] exp_res,
                           input bit inject);
        start = 1'b1;
        mode  = md;
        for (int c = 1; c <= len + 1; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
                pin("first_busy", 32'(busy), 32'd1);
                pin("first_sel_cu", 32'(sel_cu), (md == 2'b10) ? 32'd2 : 32'd3);
            end
            if (c == len - 1) begin
                pin("pre_valid", 32'(result_valid), 32'd0);
                pin("add_sel_adder", 32'(sel_adder), (md == 2'b01) ? 32'd1 : 32'd2);
            end
            if (c == len) begin
                pin("valid_at_latency", 32'(result_valid), 32'd1);
                pin("result_literal", result_total, exp_res);
                pin("done_ctl_zero", 32'({sel_cu, sel_cu_go_back, sel_adder}), 32'd0);
            end
            if (c == len + 1) pin("busy_falls", 32'(busy), 32'd0);
            if (inject && c == 5) begin
                start = 1'b1;
                mode  = 2'b00;
            end
            if (inject && c == 6) start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        pin("reset_busy", 32'(busy), 32'd0);
        pin("reset_result", result_total, 32'd0);
        rst = 1'b1;
        tick();

        // DOT with a stray start mid-run; total fixed at 1+2+..+16.
        pe_out_total = 32'd136;
        run_seq(2'b00, 2 * S + A + 1, 32'd136, 1'b1);
        tick();

        // EWISE does not capture: earlier total survives.
        pe_out_total = 32'd999;
        run_seq(2'b01, 2 * S + A + 1, 32'd136, 1'b0);
        tick();

        // DIST: sum of squares 2..17.
        pe_out_total = 32'd1784;
        run_seq(2'b10, 6 * S + A + 1, 32'd1784, 1'b0);
        tick();

        // Reserved mode: error pulse only.
        start = 1'b1;
        mode  = 2'b11;
        tick();
        start = 1'b0;
        pin("mode_err_pulse", 32'(mode_err), 32'd1);
        pin("mode_err_busy", 32'(busy), 32'd0);
        tick();
        pin("mode_err_clear", 32'(mode_err), 32'd0);

        // Reset mid-DIST, then a fresh DOT.
        start = 1'b1;
        mode  = 2'b10;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b0;
        tick();
        pin("rst_abort_busy", 32'(busy), 32'd0);
        pin("rst_abort_ctl", 32'({sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out}), 32'd0);
        rst = 1'b1;
        tick();
        pe_out_total = 32'd136;
        run_seq(2'b00, 2 * S + A + 1, 32'd136, 1'b0);
        tick();

`ifdef PE_SEQ_ABORT_EN
        start = 1'b1;
        mode  = 2'b00;
        pe_out_total = 32'd7;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pin("abort_busy", 32'(busy), 32'd0);
        pin("abort_ctl", 32'({sel_cu, sel_cu_go_back}), 32'd0);
        pin("abort_result_kept", result_total, 32'd136);
        repeat (25) tick();
        pin("abort_no_valid", 32'(result_valid), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        pin("abort_idle_start", 32'(busy), 32'd1);
        repeat (2 * S + A + 2) tick();
`endif

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            tick();
            start        = ($urandom_range(0, 3) == 0);
            mode         = 2'($urandom_range(0, 3));
            pe_out_total = $urandom;
            rst          = ($urandom_range(0, 299) != 0);
`ifdef PE_SEQ_ABORT_EN
            abort        = ($urandom_range(0, 59) == 0);
`endif
        end
        start = 1'b0;
        rst   = 1'b1;
`ifdef PE_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (100) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
